conv: RTL and testbench

CONV -- requirements
Module: conv

---
 rtl/conv.sv | 198 +++++++++++++++++++
 tb/tb_conv.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/conv.sv
// 3x3 zero-padded convolution with bias/ReLU over a 64x64 image (layer0),
// followed by 2x2 max-pooling into a 32x32 layer1.
module conv (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  output logic        busy,
  output logic [11:0] iaddr,
  input  logic [19:0] idata,
  output logic        cwr,
  output logic [11:0] caddr_wr,
  output logic [19:0] cdata_wr,
  output logic        crd,
  output logic [11:0] caddr_rd,
  input  logic [19:0] cdata_rd,
  output logic [2:0]  csel,
  output logic [5:0]  pos_row,
  output logic [5:0]  pos_col
);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_POOL, S_DONE} state_t;

  localparam logic [2:0] CSEL_L0 = 3'b001;
  localparam logic [2:0] CSEL_L1 = 3'b011;
  localparam logic [0:8][19:0] KERN = {20'h0A89E, 20'h092D5, 20'h06D43,
                                       20'h01004, 20'hF8F71, 20'hF6E54,
                                       20'hFA6D7, 20'hFC834, 20'hFAC19};
  // bias 0x01310 aligned to 32 fraction bits, plus the half-up rounding bit
  localparam logic signed [43:0] BIAS_RND = 44'sh00013108000;

  state_t state, state_nxt;

  logic [5:0]            row;
  logic [6:0]            fc;
  logic [1:0]            k;
  logic                  fetch_done;
  logic [19:0]           nc0, nc1;
  logic [2:0][2:0][19:0] win;
  logic                  pend;
  logic [5:0]            prow, pcol;
  logic [4:0]            pr, pc;
  logic [2:0]            ps;
  logic [19:0]           mx;

  logic [7:0]            rr;
  logic                  rd_ok;
  logic [19:0]           pix;
  logic signed [43:0]    acc;
  logic signed [39:0]    kx, wx;
  logic [19:0]           res, relu;
  logic [19:0]           mx_nxt;
  logic [4:0]            pr_n, pc_n;

  function automatic logic [11:0] pool_addr(input logic [4:0] r, input logic [4:0] c,
                                            input logic [1:0] s);
    return {r, s[1], c, s[0]};
  endfunction

  // Column-sliding window: each fetch step reads column fc (rows row-1..row+1)
  // in three cycles; fetch column 64 is pure padding and seeds the next row's
  // left edge with zeros.
  always_comb begin
    rr    = {2'b00, row} + {6'd0, k} - 8'd1;
    rd_ok = (state == S_CONV) && !fetch_done && !fc[6] && (rr < 8'd64);
    iaddr = rd_ok ? {rr[5:0], fc[5:0]} : '0;
    pix   = rd_ok ? idata : '0;
  end

  always_comb begin
    acc = '0;
    kx  = '0;
    wx  = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      kx  = 40'($signed(KERN[i]));
      wx  = 40'($signed(win[i / 3][i % 3]));
      acc = acc + 44'(kx * wx);
    end
    res  = 20'((acc + BIAS_RND) >>> 16);
    relu = res[19] ? '0 : res;
  end

  always_comb begin
    mx_nxt = ((ps == 3'd0) || ($signed(cdata_rd) > $signed(mx))) ? cdata_rd : mx;
    pc_n   = pc + 5'd1;
    pr_n   = (pc == 5'd31) ? pr + 5'd1 : pr;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ready) state_nxt = S_CONV;
      S_CONV:  if (pend && prow == 6'd63 && pcol == 6'd63) state_nxt = S_POOL;
      S_POOL:  if (ps == 3'd4 && pr == 5'd31 && pc == 5'd31) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0; cwr <= 1'b0; crd <= 1'b0; csel <= '0;
      caddr_wr <= '0; cdata_wr <= '0; caddr_rd <= '0;
      pos_row <= '0; pos_col <= '0;
      row <= '0; fc <= '0; k <= '0; fetch_done <= 1'b0;
      nc0 <= '0; nc1 <= '0; win <= '0; pend <= 1'b0;
      prow <= '0; pcol <= '0; pr <= '0; pc <= '0; ps <= '0; mx <= '0;
    end else begin
      cwr <= 1'b0;
      case (state)
        S_IDLE: begin
          crd  <= 1'b0;
          csel <= '0;
          if (ready) begin
            busy <= 1'b1; row <= '0; fc <= '0; k <= '0;
            fetch_done <= 1'b0; pend <= 1'b0; win <= '0;
          end
        end
        S_CONV: begin
          if (pend) begin
            pend     <= 1'b0;
            cwr      <= 1'b1;
            csel     <= CSEL_L0;
            caddr_wr <= {prow, pcol};
            cdata_wr <= relu;
            pos_row  <= prow;
            pos_col  <= pcol;
            if (prow == 6'd63 && pcol == 6'd63) begin
              ps <= 3'd5; pr <= '0; pc <= '0;
            end
          end
          if (!fetch_done) begin
            case (k)
              2'd0: nc0 <= pix;
              2'd1: nc1 <= pix;
              default: begin
                for (int unsigned r = 0; r < 3; r++) begin
                  win[r][0] <= win[r][1];
                  win[r][1] <= win[r][2];
                end
                win[0][2] <= nc0;
                win[1][2] <= nc1;
                win[2][2] <= pix;
              end
            endcase
            if (k == 2'd2) begin
              k <= '0;
              if (fc != 7'd0) begin
                pend <= 1'b1; prow <= row; pcol <= fc[5:0] - 6'd1;
              end
              if (fc == 7'd64) begin
                fc <= '0;
                if (row == 6'd63) fetch_done <= 1'b1;
                else              row <= row + 6'd1;
              end else begin
                fc <= fc + 7'd1;
              end
            end else begin
              k <= k + 2'd1;
            end
          end
        end
        S_POOL: begin
          // ps 0..3 read the 2x2 block, ps 4 writes its max, ps 5 only lets
          // the final layer0 write drain before the first read.
          if (ps == 3'd5) begin
            crd <= 1'b1; csel <= CSEL_L0; caddr_rd <= pool_addr(pr, pc, 2'd0);
            pos_row <= {1'b0, pr}; pos_col <= {1'b0, pc}; ps <= 3'd0;
          end else if (ps == 3'd4) begin
            if (pr == 5'd31 && pc == 5'd31) begin
              csel <= '0;
            end else begin
              pr <= pr_n; pc <= pc_n;
              crd <= 1'b1; csel <= CSEL_L0; caddr_rd <= pool_addr(pr_n, pc_n, 2'd0);
              pos_row <= {1'b0, pr_n}; pos_col <= {1'b0, pc_n}; ps <= 3'd0;
            end
          end else begin
            mx <= mx_nxt;
            if (ps == 3'd3) begin
              crd <= 1'b0; cwr <= 1'b1; csel <= CSEL_L1;
              caddr_wr <= {2'b00, pr, pc}; cdata_wr <= mx_nxt; ps <= 3'd4;
            end else begin
              caddr_rd <= pool_addr(pr, pc, ps[1:0] + 2'd1);
              ps <= ps + 3'd1;
            end
          end
        end
        default: begin
          busy <= 1'b0; crd <= 1'b0; csel <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv.sv
// Self-checking bench for conv: image/result memories modelled here, results
// compared against an arithmetic reference of conv+bias+ReLU and 2x2 max pool.
module tb_conv;

  logic        clk, reset, ready, busy, cwr, crd;
  logic [11:0] iaddr, caddr_wr, caddr_rd;
  logic [19:0] idata, cdata_wr, cdata_rd;
  logic [2:0]  csel;
  logic [5:0]  pos_row, pos_col;

  conv dut (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy),
    .iaddr(iaddr), .idata(idata), .cwr(cwr), .caddr_wr(caddr_wr),
    .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .csel(csel), .pos_row(pos_row), .pos_col(pos_col)
  );

  logic [19:0] img [4096];
  logic [19:0] l0  [4096];
  logic [19:0] l1  [1024];
  logic [19:0] ref0[4096];
  logic [19:0] ref1[1024];
  int kern[9] = '{43166, 37589, 27971, 4100, -28815, -37292, -22825, -14284, -21479};

  int n_cmp = 0, n_err = 0;
  int w0, w1, viol, pos_err, idle_strobe;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign idata = img[iaddr];

  // Result memory: writes captured mid-cycle, reads return data by the next edge.
  always @(negedge clk) begin
    if (cwr && crd) viol++;
    if ((cwr || crd) && !busy) idle_strobe++;
    if (cwr) begin
      if (csel == 3'b001) begin
        l0[caddr_wr] = cdata_wr; w0++;
        if ({pos_row, pos_col} != caddr_wr) pos_err++;
      end else if (csel == 3'b011) begin
        l1[caddr_wr[9:0]] = cdata_wr; w1++;
        if ({pos_row, pos_col} != {1'b0, caddr_wr[9:5], 1'b0, caddr_wr[4:0]}) pos_err++;
      end else viol++;
    end
    if (crd) begin
      if (csel == 3'b001) cdata_rd = l0[caddr_rd];
      else viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int sx20(input logic [19:0] v);
    return int'($signed(v));
  endfunction

  task automatic build_ref();
    longint s;
    logic [63:0] t;
    int rr, cc, m, v;
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++) begin
        s = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (rr >= 0 && rr < 64 && cc >= 0 && cc < 64)
              s += longint'(kern[(dr + 1) * 3 + dc + 1]) * longint'(sx20(img[rr * 64 + cc]));
          end
        s = s + longint'(4880) * 65536 + 32768;
        t = s;
        ref0[r * 64 + c] = t[35] ? 20'h0 : t[35:16];
      end
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) begin
        m = sx20(ref0[(2 * r) * 64 + 2 * c]);
        v = sx20(ref0[(2 * r) * 64 + 2 * c + 1]);  if (v > m) m = v;
        v = sx20(ref0[(2 * r + 1) * 64 + 2 * c]);  if (v > m) m = v;
        v = sx20(ref0[(2 * r + 1) * 64 + 2 * c + 1]); if (v > m) m = v;
        ref1[r * 32 + c] = 20'(m);
      end
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 4096; i++) l0[i] = 'x;
    for (int i = 0; i < 1024; i++) l1[i] = 'x;
    w0 = 0; w1 = 0; viol = 0; pos_err = 0; idle_strobe = 0;
  endtask

  task automatic finish_and_verify(input string tag);
    int n;
    n = 0;
    while (busy && n < 25000) begin @(negedge clk); n++; end
    chk({tag, ":done"}, {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk({tag, ":l0_writes"}, w0, 4096);
    chk({tag, ":l1_writes"}, w1, 1024);
    chk({tag, ":protocol"}, viol, 0);
    chk({tag, ":pos"}, pos_err, 0);
    chk({tag, ":idle_strobe"}, idle_strobe, 0);
    for (int i = 0; i < 4096; i++) chk($sformatf("%s:l0[%0d]", tag, i), {12'd0, l0[i]}, {12'd0, ref0[i]});
    for (int i = 0; i < 1024; i++) chk($sformatf("%s:l1[%0d]", tag, i), {12'd0, l1[i]}, {12'd0, ref1[i]});
  endtask

  task automatic start_run(input string tag);
    int n;
    @(negedge clk) ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!busy && n < 4) begin @(negedge clk); n++; end
    ready = 1'b0;
    chk({tag, ":start"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ":busy"}, {31'd0, busy}, 0);
    chk({tag, ":cwr"}, {31'd0, cwr}, 0);
    chk({tag, ":crd"}, {31'd0, crd}, 0);
    chk({tag, ":csel"}, {29'd0, csel}, 0);
    chk({tag, ":iaddr"}, {20'd0, iaddr}, 0);
    chk({tag, ":caddr_rd"}, {20'd0, caddr_rd}, 0);
    chk({tag, ":caddr_wr"}, {20'd0, caddr_wr}, 0);
    chk({tag, ":cdata_wr"}, {12'd0, cdata_wr}, 0);
    chk({tag, ":pos"}, {20'd0, pos_row, pos_col}, 0);
  endtask

  initial begin
    reset = 1'b1; ready = 1'b1; cdata_rd = '0;
    for (int i = 0; i < 4096; i++) img[i] = 20'($urandom_range(0, 20'hFFFFF));
    build_ref();
    clear_mon();
    #2 reset = 1'b0;
    #1 check_reset_outputs("por");

    // random image, ready held through reset release
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rand:busy_2cyc", {31'd0, busy}, 1);
    ready = 1'b0;
    finish_and_verify("rand");

    // all -1.0
    for (int i = 0; i < 4096; i++) img[i] = 20'hF0000;
    build_ref();
    clear_mon();
    start_run("neg");
    finish_and_verify("neg");
    chk("neg:L0[0]", {12'd0, l0[0]}, 32'h1A0FE);
    chk("neg:L0[1]", {12'd0, l0[1]}, 32'h1EA23);
    chk("neg:L0[64]", {12'd0, l0[64]}, 32'h0A0E6);
    chk("neg:L0[65]", {12'd0, l0[65]}, 32'h0416D);
    chk("neg:L1[0]", {12'd0, l1[0]}, 32'h1EA23);

    // all +1.0: interior goes negative and is clipped
    for (int i = 0; i < 4096; i++) img[i] = 20'h10000;
    build_ref();
    clear_mon();
    start_run("pos");
    finish_and_verify("pos");
    chk("pos:L0[interior]", {12'd0, l0[10 * 64 + 37]}, 0);

    // zero image; abort mid-conv, then a full fresh run
    for (int i = 0; i < 4096; i++) img[i] = 20'h0;
    build_ref();
    clear_mon();
    start_run("abort");
    repeat (300) @(negedge clk);
    #3 reset = 1'b0;
    #1 check_reset_outputs("abort");
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort:stays_idle", {31'd0, busy}, 0);
    clear_mon();
    start_run("zero");
    finish_and_verify("zero");
    chk("zero:L0[2047]", {12'd0, l0[2047]}, 32'h01310);
    chk("zero:L1[1023]", {12'd0, l1[1023]}, 32'h01310);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
